// File: rtl/uart_rx_os16.sv
`timescale 1ns/1ps
// uart_rx_os16 -- oversampling UART receiver (8N1-style: start, DataBits LSB-first, stop).
//
// The raw line is brought into the clock domain by a 2-FF synchroniser. Once per
// oversample tick it is shifted into a 3-entry window, and the majority of that
// window is the filtered bit value. A free-running divider produces the ticks. A
// sample counter places every decision at the middle of a bit.
//
// Ports
//   clk_i          in   1         system clock
//   reset_i        in   1         asynchronous, active-high reset
//   uart_rxd_i     in   1         raw serial input, asynchronous to clk_i, idle high
//   data_o         out  DataBits  last good received word, LSB = first bit on the line
//   data_valid_o   out  1         1-cycle strobe: data_o holds a new good word
//   framing_err_o  out  1         1-cycle strobe: stop bit sampled low, word discarded
//   busy_o         out  1         high from start-bit detect until frame end or abort
module uart_rx_os16 #(
  parameter int ClkFreq        = 50_000_000,
  parameter int BaudRate       = 115200,
  parameter int OversampleRate = 16,
  parameter int DataBits       = 8
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                uart_rxd_i,
  output logic [DataBits-1:0] data_o,
  output logic                data_valid_o,
  output logic                framing_err_o,
  output logic                busy_o
);

  // Rounded divide from the clock to the tick rate, never below 1.
  localparam int DivRaw = (ClkFreq + (BaudRate * OversampleRate) / 2) / (BaudRate * OversampleRate);
  localparam int Div    = (DivRaw < 1) ? 1 : DivRaw;
  localparam int DivW   = (Div > 1) ? $clog2(Div) : 1;
  localparam int SW     = $clog2(OversampleRate);
  localparam int BitW   = $clog2(DataBits);

  localparam logic [DivW-1:0] DivLast = DivW'(Div - 1);
  localparam logic [SW-1:0]   SLast   = SW'(OversampleRate - 1);
  localparam logic [SW-1:0]   Mid     = SW'(OversampleRate / 2 - 1);
  localparam logic [BitW-1:0] BitLast = BitW'(DataBits - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t                state_q, state_d;
  logic [DivW-1:0]       div_q, div_d;
  logic [SW-1:0]         s_q, s_d;
  logic [BitW-1:0]       bit_q, bit_d;
  logic [DataBits-1:0]   shreg_q, shreg_d;
  logic [DataBits-1:0]   data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  ferr_q, ferr_d;
  logic                  sync1_q, sync1_d;
  logic                  sync2_q, sync2_d;
  logic [2:0]            samp_q, samp_d;
  logic                  tick;
  logic                  maj;
  logic [SW-1:0]         s_inc;

  function automatic logic majority3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

  always_comb begin
    sync1_d = uart_rxd_i;
    sync2_d = sync1_q;

    tick  = (div_q == DivLast);
    div_d = tick ? '0 : div_q + 1'b1;

    // The window includes the sample taken on this tick, so a decision made
    // on a tick reflects the three most recent samples, the newest included.
    samp_d = samp_q;
    if (tick) begin
      samp_d = {samp_q[1:0], sync2_q};
    end
    maj = majority3(samp_d);

    s_inc = (s_q == SLast) ? '0 : s_q + 1'b1;

    state_d = state_q;
    s_d     = s_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;

    if (tick) begin
      case (state_q)
        S_IDLE: begin
          if (!sync2_q) begin
            state_d = S_START;
            s_d     = '0;
          end
        end
        S_START: begin
          s_d = s_inc;
          // Mid-start re-check rejects short glitches that tripped the detector.
          if (s_q == Mid) begin
            if (maj) begin
              state_d = S_IDLE;
            end else begin
              state_d = S_DATA;
              bit_d   = '0;
            end
          end
        end
        S_DATA: begin
          s_d = s_inc;
          if (s_q == Mid) begin
            shreg_d = {maj, shreg_q[DataBits-1:1]};
            if (bit_q == BitLast) begin
              state_d = S_STOP;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end
        end
        S_STOP: begin
          s_d = s_inc;
          // Leave at mid-stop so a start bit that immediately follows is caught.
          if (s_q == Mid) begin
            if (maj) begin
              data_d  = shreg_q;
              valid_d = 1'b1;
              state_d = S_IDLE;
            end else begin
              ferr_d  = 1'b1;
              state_d = S_WAIT_HIGH;
            end
          end
        end
        S_WAIT_HIGH: begin
          if (maj) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      s_q     <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      samp_q  <= 3'b111;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      s_q     <= s_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      samp_q  <= samp_d;
    end
  end

  assign data_o        = data_q;
  assign data_valid_o  = valid_q;
  assign framing_err_o = ferr_q;
  assign busy_o        = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_os16.sv
`timescale 1ns/1ps
// Bench for uart_rx_os16 at 1.6 MHz / 10 kbaud (160 clocks per bit).
module tb_uart_rx_os16;
  localparam int ClkFreq  = 1_600_000;
  localparam int BaudRate = 10_000;
  localparam int Os       = 16;
  localparam int DataBits = 8;
  localparam int BitClks  = ClkFreq / BaudRate;

  logic       clk = 1'b0;
  logic       reset_i;
  logic       rxd;
  logic [7:0] data_o;
  logic       data_valid_o;
  logic       framing_err_o;
  logic       busy_o;

  always #5 clk = ~clk;

  uart_rx_os16 #(
    .ClkFreq(ClkFreq),
    .BaudRate(BaudRate),
    .OversampleRate(Os),
    .DataBits(DataBits)
  ) dut (
    .clk_i(clk),
    .reset_i(reset_i),
    .uart_rxd_i(rxd),
    .data_o(data_o),
    .data_valid_o(data_valid_o),
    .framing_err_o(framing_err_o),
    .busy_o(busy_o)
  );

  typedef struct {
    bit         is_err;
    logic [7:0] data;
  } ev_t;

  ev_t        exp_q[$];
  ev_t        mon_ev;
  logic [7:0] last_good = 8'h00;
  logic       prev_strobe = 1'b0;
  int         n_checks = 0;
  int         n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every strobe consumes the oldest expected event.
  always @(negedge clk) begin
    if (!reset_i && (data_valid_o || framing_err_o)) begin
      check("strobe_exclusive", 32'(data_valid_o & framing_err_o), 32'd0);
      check("strobe_not_consecutive", 32'(prev_strobe), 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_strobe_queue_size", 32'(exp_q.size()), 32'd1);
      end else begin
        mon_ev = exp_q.pop_front();
        check("strobe_kind_is_err", 32'(framing_err_o), 32'(mon_ev.is_err));
        if (!mon_ev.is_err) begin
          check("data", 32'(data_o), 32'(mon_ev.data));
          last_good = mon_ev.data;
        end else begin
          check("data_kept_on_ferr", 32'(data_o), 32'(last_good));
        end
      end
    end
    prev_strobe = data_valid_o | framing_err_o;
  end

  task automatic drive_bit(input logic v, input int clks);
    rxd = v;
    repeat (clks) @(negedge clk);
  endtask

  task automatic idle(input int clks);
    drive_bit(1'b1, clks);
  endtask

  // Reference: a good stop bit delivers the byte as sent; a low stop bit yields
  // a framing error and no data.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int bclk);
    ev_t e;
    e.is_err = !stop_ok;
    e.data   = b;
    exp_q.push_back(e);
    drive_bit(1'b0, bclk);
    for (int i = 0; i < 8; i++) drive_bit(b[i], bclk);
    drive_bit(stop_ok, bclk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] bb;
    logic [7:0] partial;
    bit         ok;
    int         bclk;

    rxd     = 1'b1;
    reset_i = 1'b1;
    repeat (5) @(negedge clk);
    check("reset_data", 32'(data_o), 32'd0);
    check("reset_valid", 32'(data_valid_o), 32'd0);
    check("reset_ferr", 32'(framing_err_o), 32'd0);
    check("reset_busy", 32'(busy_o), 32'd0);
    reset_i = 1'b0;
    idle(2 * BitClks);

    // Single frame
    send_frame(8'hA5, 1'b1, BitClks);
    idle(BitClks);
    check("t1_busy", 32'(busy_o), 32'd0);
    check("t1_data", 32'(data_o), 32'hA5);
    check("t1_pending", 32'(exp_q.size()), 32'd0);

    // Back-to-back frames, no idle gap
    send_frame(8'h00, 1'b1, BitClks);
    send_frame(8'hFF, 1'b1, BitClks);
    send_frame(8'h55, 1'b1, BitClks);
    idle(BitClks);
    check("t2_pending", 32'(exp_q.size()), 32'd0);
    check("t2_data", 32'(data_o), 32'h55);

    // Short glitch on idle line
    drive_bit(1'b0, 20);
    idle(BitClks);
    check("t3_busy", 32'(busy_o), 32'd0);
    check("t3_data", 32'(data_o), 32'h55);

    // Framing error followed by a held-low line
    send_frame(8'h3C, 1'b0, BitClks);
    drive_bit(1'b0, 3 * BitClks);
    check("t4_busy_while_low", 32'(busy_o), 32'd1);
    idle(BitClks);
    check("t4_busy_after_high", 32'(busy_o), 32'd0);
    check("t4_data", 32'(data_o), 32'h55);
    check("t4_pending", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of the data bits
    partial = 8'h5A;
    drive_bit(1'b0, BitClks);
    for (int i = 0; i < 4; i++) drive_bit(partial[i], BitClks);
    drive_bit(partial[4], BitClks / 2);
    check("t5_busy_before_reset", 32'(busy_o), 32'd1);
    reset_i = 1'b1;
    rxd     = 1'b1;
    repeat (3) @(negedge clk);
    check("t5_reset_data", 32'(data_o), 32'd0);
    check("t5_reset_valid", 32'(data_valid_o), 32'd0);
    check("t5_reset_busy", 32'(busy_o), 32'd0);
    last_good = 8'h00;
    reset_i = 1'b0;
    idle(BitClks);
    check("t5_busy_after_reset", 32'(busy_o), 32'd0);
    send_frame(8'h81, 1'b1, BitClks);
    idle(BitClks);
    check("t5_data", 32'(data_o), 32'h81);
    check("t5_pending", 32'(exp_q.size()), 32'd0);

    // Baud rate about 3% slow and 3% fast
    send_frame(8'hC3, 1'b1, 165);
    idle(BitClks);
    send_frame(8'hC3, 1'b1, 155);
    idle(BitClks);
    check("t6_pending", 32'(exp_q.size()), 32'd0);

    // Randomised frames: random data, rate, stop validity and gaps
    for (int n = 0; n < 12; n++) begin
      bb   = 8'($urandom);
      ok   = ($urandom_range(0, 4) != 0);
      bclk = int'($urandom_range(155, 165));
      send_frame(bb, ok, bclk);
      if (!ok) begin
        drive_bit(1'b0, int'($urandom_range(0, 2)) * BitClks);
        idle(BitClks);
      end else begin
        idle(int'($urandom_range(0, 2)) * (bclk / 2));
      end
    end
    idle(2 * BitClks);
    check("final_pending", 32'(exp_q.size()), 32'd0);
    check("final_busy", 32'(busy_o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
